// File: rtl/cart_mem_arbiter.sv
// Cartridge SDRAM arbiter: serialises HPS ROM-download writes and console cart reads
// onto the single-port SDRAM with one outstanding access, writes taking priority.
module cart_mem_arbiter #(
    parameter int AW  = 25,
    parameter int RAW = 20,
    parameter int TMO = 255
) (
    input  logic           clk_sys,
    input  logic           reset,
    input  logic           dl_active,
    input  logic           wr_req,
    input  logic [AW-1:0]  wr_addr,
    input  logic [7:0]     wr_data,
    output logic           wr_pending,
    output logic           wr_overflow,
    input  logic           rd_req,
    input  logic [RAW-1:0] rd_addr,
    output logic [7:0]     rd_data,
    output logic           rd_valid,
    output logic           rd_err,
    output logic [5:0]     cart_pages,
    output logic [AW-1:0]  mem_addr,
    output logic [7:0]     mem_din,
    output logic           mem_we,
    output logic           mem_rd,
    input  logic [7:0]     mem_dout,
    input  logic           mem_ready
);
    typedef enum logic [2:0] {IDLE, ISSUE_W, WAIT_W, ISSUE_R, WAIT_R} state_t;

    state_t         state, state_nxt;
    logic           wl_full;
    logic [AW-1:0]  wl_addr;
    logic [7:0]     wl_data;
    logic           rl_full;
    logic [RAW-1:0] rl_addr;
    logic [AW-1:0]  addr_hold;
    logic [7:0]     din_hold;
    logic [7:0]     tmo_cnt;
    logic           issue_w, issue_r, in_wait, wait_done;

    assign issue_w    = (state == ISSUE_W);
    assign issue_r    = (state == ISSUE_R);
    assign in_wait    = (state == WAIT_W) || (state == WAIT_R);
    assign wait_done  = mem_ready || (tmo_cnt == 8'(TMO - 1));
    assign wr_pending = wl_full;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wl_full)                     state_nxt = ISSUE_W;
                else if (rl_full && !dl_active)  state_nxt = ISSUE_R;
            end
            ISSUE_W:        state_nxt = WAIT_W;
            ISSUE_R:        state_nxt = WAIT_R;
            WAIT_W, WAIT_R: if (wait_done) state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    // The issue cycle drives straight from the latch, so a read overwritten during the
    // IDLE decision cycle still goes out with its newest address.
    always_comb begin
        mem_we   = issue_w;
        mem_rd   = issue_r;
        mem_addr = addr_hold;
        mem_din  = din_hold;
        if (issue_w) begin
            mem_addr = wl_addr;
            mem_din  = wl_data;
        end else if (issue_r) begin
            mem_addr = AW'(rl_addr);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wl_full     <= 1'b0;
            wl_addr     <= '0;
            wl_data     <= '0;
            wr_overflow <= 1'b0;
            cart_pages  <= '0;
        end else if (wr_req && (!wl_full || issue_w)) begin
            wl_full    <= 1'b1;
            wl_addr    <= wr_addr;
            wl_data    <= wr_data;
            cart_pages <= wr_addr[19:14];
        end else begin
            if (wr_req)  wr_overflow <= 1'b1;
            if (issue_w) wl_full     <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rl_full <= 1'b0;
            rl_addr <= '0;
        end else if (rd_req) begin
            rl_full <= 1'b1;
            rl_addr <= rd_addr;
        end else if (issue_r) begin
            rl_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            addr_hold <= '0;
            din_hold  <= '0;
            tmo_cnt   <= '0;
        end else begin
            if (issue_w) begin
                addr_hold <= wl_addr;
                din_hold  <= wl_data;
            end else if (issue_r) begin
                addr_hold <= AW'(rl_addr);
            end
            if (issue_w || issue_r) tmo_cnt <= '0;
            else if (in_wait)       tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rd_data  <= 8'hFF;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            if (state == WAIT_R && wait_done) begin
                rd_valid <= 1'b1;
                rd_err   <= !mem_ready;
                rd_data  <= mem_ready ? mem_dout : 8'hFF;
            end
        end
    end
endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Bench for cart_mem_arbiter: directed scenarios and a randomized run, every output
// compared each cycle against a transaction-timed reference model and an SDRAM model.
module tb_cart_mem_arbiter;
    localparam int AW  = 25;
    localparam int RAW = 20;
    localparam int TMO = 255;

    logic           clk_sys = 1'b0;
    logic           reset = 1'b0;
    logic           dl_active = 1'b0;
    logic           wr_req = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [7:0]     wr_data = '0;
    logic           wr_pending, wr_overflow;
    logic           rd_req = 1'b0;
    logic [RAW-1:0] rd_addr = '0;
    logic [7:0]     rd_data;
    logic           rd_valid, rd_err;
    logic [5:0]     cart_pages;
    logic [AW-1:0]  mem_addr;
    logic [7:0]     mem_din;
    logic           mem_we, mem_rd;
    logic [7:0]     mem_dout = '0;
    logic           mem_ready = 1'b0;

    cart_mem_arbiter #(.AW(AW), .RAW(RAW), .TMO(TMO)) dut (
        .clk_sys(clk_sys), .reset(reset), .dl_active(dl_active),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_pending(wr_pending), .wr_overflow(wr_overflow),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_err(rd_err), .cart_pages(cart_pages),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_dout(mem_dout), .mem_ready(mem_ready)
    );

    always #5 clk_sys = ~clk_sys;

    int unsigned n_tests = 0, n_fail = 0, cyc = 0;

    // reference model: request latches plus the single outstanding access (kind, issue cycle)
    logic          m_wv, m_rv, m_ovf, m_valid, m_err;
    logic [AW-1:0] m_wa, m_last_addr;
    logic [RAW-1:0] m_ra;
    logic [7:0]    m_wd, m_last_din, m_rdata;
    logic [5:0]    m_pages;
    int unsigned   acc_kind, acc_iss;
    logic          exp_we, exp_rd;
    logic [AW-1:0] exp_addr;
    logic [7:0]    exp_din;

    // SDRAM model and DUT activity log
    logic [7:0]    mem_arr [int unsigned];
    int unsigned   sd_mode = 0, sd_delay = 2, sd_due = 0;
    logic          sd_busy = 1'b0, sd_is_rd = 1'b0;
    logic [AW-1:0] sd_addr = '0;
    logic          s_we = 1'b0, s_rd = 1'b0;
    logic [AW-1:0] s_addr = '0;
    logic [7:0]    s_din = '0;
    int unsigned   n_we = 0, n_rd = 0, n_valid = 0, last_rd_cyc = 0, last_valid_cyc = 0;
    logic [AW-1:0] last_rd_addr = '0;
    logic [7:0]    v_data = '0;
    logic          v_err = 1'b0;
    logic [AW-1:0] we_addr_q[$];
    logic [7:0]    we_data_q[$];
    int unsigned   cmd_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_exp(input int unsigned c);
        exp_we   = (acc_kind == 1) && (acc_iss == c);
        exp_rd   = (acc_kind == 2) && (acc_iss == c);
        exp_addr = exp_we ? m_wa : (exp_rd ? AW'(m_ra) : m_last_addr);
        exp_din  = exp_we ? m_wd : m_last_din;
    endtask

    task automatic model_reset();
        m_wv = 0; m_rv = 0; m_ovf = 0; m_valid = 0; m_err = 0;
        m_wa = '0; m_wd = '0; m_ra = '0; m_last_addr = '0; m_last_din = '0;
        m_rdata = 8'hFF; m_pages = '0; acc_kind = 0; acc_iss = 0;
        set_exp(cyc);
    endtask

    // advance the model over the edge that ends cycle k, using the inputs seen during k
    task automatic model_step(input int unsigned k);
        logic iw, ir;
        iw = (acc_kind == 1) && (acc_iss == k);
        ir = (acc_kind == 2) && (acc_iss == k);
        if (iw) begin m_last_addr = m_wa; m_last_din = m_wd; end
        if (ir) m_last_addr = AW'(m_ra);
        m_valid = 0; m_err = 0;
        if (acc_kind == 0) begin
            if (m_wv) begin acc_kind = 1; acc_iss = k + 1; end
            else if (m_rv && !dl_active) begin acc_kind = 2; acc_iss = k + 1; end
        end else if (k > acc_iss) begin
            if (mem_ready || (k - acc_iss) == TMO) begin
                if (acc_kind == 2) begin
                    m_valid = 1;
                    m_err   = !mem_ready;
                    m_rdata = mem_ready ? mem_dout : 8'hFF;
                end
                acc_kind = 0;
            end
        end
        if (wr_req) begin
            if (!m_wv || iw) begin
                m_wv = 1; m_wa = wr_addr; m_wd = wr_data; m_pages = wr_addr[19:14];
            end else m_ovf = 1;
        end else if (iw) m_wv = 0;
        if (rd_req) begin m_rv = 1; m_ra = rd_addr; end
        else if (ir) m_rv = 0;
        set_exp(k + 1);
    endtask

    task automatic sdram_step();
        int unsigned a;
        mem_ready = 1'b0;
        if (s_we || s_rd) begin
            if (s_we) mem_arr[int'(s_addr)] = s_din;
            sd_busy = 1; sd_is_rd = s_rd; sd_addr = s_addr;
            if (sd_mode == 2 || (sd_mode == 0 && $urandom_range(49) == 0)) sd_due = 32'hFFFF_FFFF;
            else if (sd_mode == 1) sd_due = cyc - 1 + sd_delay;
            else sd_due = cyc - 1 + $urandom_range(6, 1);
        end
        if (sd_busy && cyc == sd_due) begin
            a = int'(sd_addr);
            mem_ready = 1'b1;
            mem_dout  = sd_is_rd ? (mem_arr.exists(a) ? mem_arr[a] : (8'(a) ^ 8'h5A)) : 8'($urandom);
            sd_busy   = 0;
        end else if (sd_mode == 0 && !sd_busy && $urandom_range(29) == 0) begin
            mem_ready = 1'b1;
            mem_dout  = 8'($urandom);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
        chk("mem_we", mem_we, exp_we);
        chk("mem_rd", mem_rd, exp_rd);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_din", mem_din, exp_din);
        chk("wr_pending", wr_pending, m_wv);
        chk("wr_overflow", wr_overflow, m_ovf);
        chk("cart_pages", cart_pages, m_pages);
        chk("rd_valid", rd_valid, m_valid);
        chk("rd_err", rd_err, m_err);
        chk("rd_data", rd_data, m_rdata);
        s_we = mem_we; s_rd = mem_rd; s_addr = mem_addr; s_din = mem_din;
        if (mem_we) begin n_we++; we_addr_q.push_back(mem_addr); we_data_q.push_back(mem_din); cmd_q.push_back(1); end
        if (mem_rd) begin n_rd++; last_rd_cyc = cyc; last_rd_addr = mem_addr; cmd_q.push_back(2); end
        if (rd_valid) begin n_valid++; last_valid_cyc = cyc; v_data = rd_data; v_err = rd_err; end
        @(posedge clk_sys); #1;
        if (reset) model_reset(); else model_step(cyc);
        cyc++;
        sdram_step();
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int unsigned n0, input int unsigned budget, input string name);
        int unsigned i = 0;
        while (n_valid == n0 && i < budget) begin tick(); i++; end
        chk(name, n_valid - n0, 1);
    endtask

    int unsigned c0, n0;

    initial begin
        model_reset();
        #1 reset = 1'b1;
        tick(); tick(); tick();
        reset = 1'b0;
        chk("rst_rd_data", rd_data, 8'hFF);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_flags", {wr_pending, wr_overflow, rd_valid, rd_err, mem_we, mem_rd}, 0);
        chk("rst_pages", cart_pages, 0);

        // single read, ready 3 cycles after mem_rd
        mem_arr[32'h123] = 8'hA5;
        sd_mode = 1; sd_delay = 3;
        n0 = n_valid; c0 = cyc;
        rd_req = 1'b1; rd_addr = 20'h00123;
        wait_valid(n0, 20, "rd1_done");
        chk("rd1_mem_rd_cyc", last_rd_cyc - c0, 2);
        chk("rd1_addr", last_rd_addr, 25'h123);
        chk("rd1_valid_cyc", last_valid_cyc - c0, 6);
        chk("rd1_data", v_data, 8'hA5);
        chk("rd1_err", v_err, 0);
        repeat (4) tick();
        chk("rd1_one_pulse", n_valid - n0, 1);

        // write burst into page 1
        sd_delay = 2;
        we_addr_q.delete(); we_data_q.delete();
        n0 = n_we;
        for (int i = 0; i < 4; i++) begin
            wr_req = 1'b1; wr_addr = AW'(32'h4000 + i); wr_data = 8'(8'hC0 + i);
            repeat (8) tick();
        end
        chk("wb_count", n_we - n0, 4);
        for (int i = 0; i < 4; i++) begin
            chk("wb_addr", we_addr_q[i], 32'h4000 + i);
            chk("wb_data", we_data_q[i], 32'hC0 + i);
        end
        chk("wb_pages", cart_pages, 1);
        chk("wb_ovf", wr_overflow, 0);

        // simultaneous write and read: write first
        cmd_q.delete();
        n0 = n_valid; c0 = cyc;
        wr_req = 1'b1; wr_addr = 25'h10; wr_data = 8'h3C;
        rd_req = 1'b1; rd_addr = 20'h20;
        wait_valid(n0, 30, "sim_done");
        chk("sim_first_we", cmd_q[0], 1);
        chk("sim_then_rd", cmd_q[1], 2);
        chk("sim_rd_cyc", last_rd_cyc - c0, 6);
        chk("sim_rd_data", v_data, 8'h7A);
        chk("sim_wr_stored", mem_arr[32'h10], 8'h3C);
        repeat (3) tick();

        // overflow while the SDRAM withholds ready
        sd_mode = 2;
        n0 = n_we;
        wr_req = 1'b1; wr_addr = 25'h8000; wr_data = 8'h11; tick();
        wr_req = 1'b1; wr_addr = 25'h1C001; wr_data = 8'h22; tick();
        repeat (4) tick();
        chk("ovf_set", wr_overflow, 1);
        chk("ovf_pages", cart_pages, 2);
        chk("ovf_one_we", n_we - n0, 1);
        repeat (270) tick();
        chk("ovf_sticky", wr_overflow, 1);
        do_reset();
        chk("ovf_cleared", wr_overflow, 0);

        // read timeout, then a normal read
        n0 = n_valid;
        rd_req = 1'b1; rd_addr = 20'h55;
        wait_valid(n0, 300, "tmo_done");
        chk("tmo_latency", last_valid_cyc - (last_rd_cyc + 1), TMO);
        chk("tmo_err", v_err, 1);
        chk("tmo_data", v_data, 8'hFF);
        sd_mode = 1; sd_delay = 2;
        n0 = n_valid;
        rd_req = 1'b1; rd_addr = 20'h66;
        wait_valid(n0, 20, "tmo_next_done");
        chk("tmo_next_data", v_data, 8'h3C);
        chk("tmo_next_err", v_err, 0);

        // reset during WAIT_R, late ready afterwards
        sd_mode = 2;
        n0 = n_rd;
        rd_req = 1'b1; rd_addr = 20'h77;
        for (int i = 0; i < 10 && n_rd == n0; i++) tick();
        repeat (4) tick();
        n0 = n_valid;
        do_reset();
        mem_ready = 1'b1; mem_dout = 8'h99;
        repeat (6) tick();
        chk("rst_late_no_valid", n_valid - n0, 0);
        chk("rst_late_rd_data", rd_data, 8'hFF);
        chk("rst_late_addr", mem_addr, 0);

        // reads held off during download
        sd_mode = 1; sd_delay = 2;
        dl_active = 1'b1;
        n0 = n_rd;
        rd_req = 1'b1; rd_addr = 20'h88;
        repeat (10) tick();
        chk("dl_no_rd", n_rd - n0, 0);
        dl_active = 1'b0; c0 = cyc;
        for (int i = 0; i < 10 && n_rd == n0; i++) tick();
        chk("dl_rd_cyc", last_rd_cyc - c0, 1);
        n0 = n_valid - ((last_valid_cyc > last_rd_cyc) ? 1 : 0);
        wait_valid(n0, 20, "dl_done");
        chk("dl_data", v_data, 8'hD2);

        // randomized traffic
        sd_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if ($urandom_range(49) == 0) dl_active = ~dl_active;
            if ($urandom_range(9) == 0) begin
                wr_req = 1'b1; wr_addr = AW'($urandom); wr_data = 8'($urandom);
            end
            if ($urandom_range(4) == 0) begin
                rd_req = 1'b1; rd_addr = RAW'($urandom);
            end
            tick();
        end
        dl_active = 1'b0;
        repeat (300) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cart_mem_arbiter.md
Name: cart_mem_arbiter

Overview:
- Shares the single-port cartridge SDRAM between two requesters: the HPS ROM download writer (ioctl write strobes) and the console cartridge read port.
- Sits between the hps_io/console logic and the sdram controller, replacing the direct address mux.
- Serialises requests with one outstanding SDRAM access at a time and gives writes priority.
- Holds each requester's request in a one-entry latch, bounds every access with a timeout, and tracks the cart page count.

Parameters:
- AW, 25, SDRAM byte address width.
- RAW, 20, cartridge read address width; zero-extended to AW.
- TMO, 255, cycles to wait for mem_ready before aborting an access (8-bit counter).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- dl_active  in  1  ROM download in progress; reads are stalled while high.
- wr_req  in  1  one-cycle write strobe.
- wr_addr  in  AW  write byte address.
- wr_data  in  8  write byte.
- wr_pending  out  1  write latch occupied.
- wr_overflow  out  1  sticky; a write strobe was dropped.
- rd_req  in  1  one-cycle read strobe.
- rd_addr  in  RAW  read byte address.
- rd_data  out  8  read result, held until the next read completes.
- rd_valid  out  1  one-cycle pulse when rd_data updates.
- rd_err  out  1  asserted together with rd_valid when the read timed out.
- cart_pages  out  6  wr_addr[19:14] of the last accepted write.
- mem_addr  out  AW  SDRAM address.
- mem_din  out  8  SDRAM write data.
- mem_we  out  1  one-cycle write command.
- mem_rd  out  1  one-cycle read command.
- mem_dout  in  8  SDRAM read data, valid with mem_ready.
- mem_ready  in  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any state): FSM goes to IDLE, both latches are cleared.
  - Output reset values: rd_data = 8'hFF; cart_pages = 0; mem_addr = 0; mem_din = 0; all strobes and flags = 0.
  - An in-flight SDRAM access is abandoned, and its completion pulse after reset is ignored.
- Latches:
  - wr_req with the write latch empty, or emptied in the same cycle by issue: capture addr and data, set wr_pending, update cart_pages.
  - wr_req with the latch full and not issuing this cycle: drop the strobe and set wr_overflow (sticky until reset).
  - rd_req: capture rd_addr into the read latch. A new rd_req while a read is latched or in flight overwrites the latched address only if that read has not yet been issued; otherwise it is latched as the next read.
  - Simultaneous wr_req and rd_req: both are captured.
- FSM:
  - IDLE: if the write latch is full, go to ISSUE_W. Else if the read latch is full and dl_active=0, go to ISSUE_R.
  - ISSUE_W: mem_we=1 for exactly one cycle, mem_addr=wr_addr, mem_din=wr_data. Clear the write latch. Go to WAIT_W.
  - ISSUE_R: mem_rd=1 for exactly one cycle, mem_addr={0,rd_addr}. Clear the read latch. Go to WAIT_R.
  - WAIT_W / WAIT_R: timeout counter cleared on entry and incremented each cycle.
    - mem_ready arrives: go to IDLE. In WAIT_R, register mem_dout into rd_data and pulse rd_valid the next cycle with rd_err=0.
    - Counter reaches TMO: go to IDLE. In WAIT_R, rd_data=8'hFF, rd_valid=1, rd_err=1.
- Priority: a pending write always wins at IDLE. A read waits through any number of writes; no starvation protection is needed because downloads are finite.
- Latency: rd_req at cycle 0 → mem_rd at cycle 2 (capture, then IDLE decision) → mem_ready at cycle n → rd_valid at n+1.
- mem_ready outside WAIT states is ignored.
- mem_we and mem_rd are never high together and never high in consecutive cycles.
- dl_active falling with a latched read: the read issues on the next IDLE evaluation.

Test Plan:
- Single read: rd_addr=20'h00123, mem model returns 8'hA5 with ready 3 cycles after mem_rd → mem_rd at cycle 2, mem_addr=25'h123, rd_data=A5, rd_valid one pulse at cycle 6, rd_err=0.
- Write burst: 4 wr_req one every 8 cycles, addr 0x4000–0x4003, ready 2 cycles after mem_we → 4 mem_we pulses with matching addr/data, cart_pages=1, wr_overflow=0.
- Same-cycle wr_req (0x10, 8'h3C) and rd_req (0x20) → mem_we issues first; mem_rd issues after the write's mem_ready; read returns model data.
- Overflow: two wr_req back-to-back while the SDRAM model withholds ready → second write dropped, wr_overflow=1 and held until reset.
- Timeout: read with mem_ready never asserted → rd_valid, rd_err=1, rd_data=FF exactly TMO cycles after entering WAIT_R; FSM accepts the next read.
- Reset mid-access: assert reset in WAIT_R, then deliver a late mem_ready → no rd_valid, outputs at reset values, rd_data=FF; dl_active=1 with rd_req → no mem_rd until dl_active drops.
